// File: rtl/systolic_drain_ctrl_if.sv
// Result stream from the drain controller to the output interface.
// Valid/ready handshake; msg is only meaningful while val is high.
interface systolic_drain_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] msg;
  logic             val;
  logic             rdy;

  modport master (
    output msg,
    output val,
    input  rdy
  );

  modport slave (
    input  msg,
    input  val,
    output rdy
  );
endinterface

// File: rtl/systolic_drain_ctrl.sv
// Drains SIZE x SIZE PE accumulators onto a val/rdy stream after a settle
// interval, then pulses a global accumulator clear and done.
module systolic_drain_ctrl #(
  parameter int SIZE   = 16,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    col_major_i,
  output logic                    busy_o,
  output logic [$clog2(SIZE)-1:0] row_sel_o,
  output logic [$clog2(SIZE)-1:0] col_sel_o,
  input  logic [WIDTH-1:0]        pe_result_i,
  systolic_drain_ctrl_if.master   out,
  output logic                    acc_clr_o,
  output logic                    done_o
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SEND,
    S_CLEAR
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   col_q, col_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            order_q, order_d;

  logic            xfer;
  logic            last_pe;
  logic            val;
  logic            clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      order_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
    end
  end

  assign xfer    = val & out.rdy;
  assign last_pe = (row_q == LAST) & (col_q == LAST);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    order_d = order_q;
    val     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          order_d = col_major_i;
          row_d   = '0;
          col_d   = '0;
          if (SETTLE > 0) begin
            state_d = S_SETTLE;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SEND: begin
        val = 1'b1;
        if (xfer) begin
          if (last_pe) begin
            state_d = S_CLEAR;
            row_d   = '0;
            col_d   = '0;
          end else if (!order_q) begin
            // row-major: column is the fast index
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + AW'(1);
            end else begin
              col_d = col_q + AW'(1);
            end
          end else begin
            if (row_q == LAST) begin
              row_d = '0;
              col_d = col_q + AW'(1);
            end else begin
              row_d = row_q + AW'(1);
            end
          end
        end
      end
      S_CLEAR: begin
        clr     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out.val   = val;
  assign out.msg   = pe_result_i;
  assign row_sel_o = row_q;
  assign col_sel_o = col_q;
  assign busy_o    = (state_q != S_IDLE);
  assign acc_clr_o = clr;
  assign done_o    = clr;

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Scoreboard bench for systolic_drain_ctrl: SETTLE=6 and SETTLE=0 instances,
// SIZE=4, with a PE result model keyed on row/col and a per-test seed.
module tb_systolic_drain_ctrl;
  localparam int SIZE  = 4;
  localparam int WIDTH = 32;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start;
  logic        col_major;
  logic        rdy;
  logic        use0;
  logic [15:0] seed;

  systolic_drain_ctrl_if #(.WIDTH(WIDTH)) if6 ();
  systolic_drain_ctrl_if #(.WIDTH(WIDTH)) if0 ();

  logic          busy6, busy0, clr6, clr0, done6, done0;
  logic [AW-1:0] row6, col6, row0, col0;
  logic [WIDTH-1:0] pe6, pe0;

  function automatic logic [WIDTH-1:0] pe_model(logic [15:0] s, int r, int c);
    return {s, 8'(r), 8'(c)};
  endfunction

  assign pe6 = pe_model(seed, int'(row6), int'(col6));
  assign pe0 = pe_model(seed, int'(row0), int'(col0));
  assign if6.rdy = use0 ? 1'b0 : rdy;
  assign if0.rdy = use0 ? rdy : 1'b0;

  systolic_drain_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .SETTLE(6)) dut (
    .clk(clk), .rst(rst),
    .start_i(use0 ? 1'b0 : start), .col_major_i(col_major),
    .busy_o(busy6), .row_sel_o(row6), .col_sel_o(col6),
    .pe_result_i(pe6), .out(if6),
    .acc_clr_o(clr6), .done_o(done6)
  );

  systolic_drain_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst),
    .start_i(use0 ? start : 1'b0), .col_major_i(col_major),
    .busy_o(busy0), .row_sel_o(row0), .col_sel_o(col0),
    .pe_result_i(pe0), .out(if0),
    .acc_clr_o(clr0), .done_o(done0)
  );

  logic          val_m, busy_m, clr_m, done_m;
  logic [AW-1:0] row_m, col_m;
  logic [WIDTH-1:0] msg_m;
  assign val_m  = use0 ? if0.val : if6.val;
  assign msg_m  = use0 ? if0.msg : if6.msg;
  assign busy_m = use0 ? busy0 : busy6;
  assign clr_m  = use0 ? clr0 : clr6;
  assign done_m = use0 ? done0 : done6;
  assign row_m  = use0 ? row0 : row6;
  assign col_m  = use0 ? col0 : col6;

  typedef struct {
    int r;
    int c;
    logic [WIDTH-1:0] m;
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic run_drain(input bit order, input bit bp, input bit extra,
                           input int abort_after, input int tail);
    int cyc, xf, sc, first_val, last_xf, settle, exp_clr;
    int prow, pcol;
    bit prev_stall, fin;
    exp_t e;
    settle = use0 ? 0 : 6;
    q.delete();
    for (int i = 0; i < SIZE * SIZE; i++) begin
      e.r = order ? i % SIZE : i / SIZE;
      e.c = order ? i / SIZE : i % SIZE;
      e.m = pe_model(seed, e.r, e.c);
      q.push_back(e);
    end
    start = 1'b1;
    col_major = order;
    rdy = 1'b1;
    cyc = 0; xf = 0; sc = 0; first_val = -1; last_xf = -1;
    prow = 0; pcol = 0; prev_stall = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      col_major = 1'($urandom_range(0, 1));
      if (cyc > 200) begin
        vectors++; miscompares++;
        $display("FAIL timeout: cycle %0d, transfers %0d, required 16", cyc, xf);
        break;
      end
      if (abort_after > 0 && xf == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy_m, val_m, clr_m, done_m} !== 4'b0 || row_m !== 0 || col_m !== 0) begin
          miscompares++;
          $display("FAIL abort_reset: busy=%b val=%b clr=%b done=%b row=%0d col=%0d, required all 0",
                   busy_m, val_m, clr_m, done_m, row_m, col_m);
        end
        for (int t = 0; t < 3; t++) begin
          @(negedge clk);
          vectors++;
          if (clr_m !== 1'b0 || busy_m !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: clr=%b busy=%b, required 0 0", clr_m, busy_m);
          end
        end
        q.delete();
        return;
      end
      if (val_m) begin
        if (first_val < 0) begin
          first_val = cyc;
          vectors++;
          if (cyc != settle + 1) begin
            miscompares++;
            $display("FAIL first_val: cycle %0d, required %0d", cyc, settle + 1);
          end
        end
        if (prev_stall) begin
          vectors++;
          if (int'(row_m) != prow || int'(col_m) != pcol) begin
            miscompares++;
            $display("FAIL hold: row=%0d col=%0d, required %0d %0d", row_m, col_m, prow, pcol);
          end
        end
        rdy = bp ? (sc % 3 == 0) : 1'b1;
        sc++;
        if (rdy) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_xfer: row=%0d col=%0d, required none", row_m, col_m);
          end else begin
            e = q.pop_front();
            if (int'(row_m) != e.r || int'(col_m) != e.c || msg_m !== e.m) begin
              miscompares++;
              $display("FAIL xfer%0d: row=%0d col=%0d msg=%h, required %0d %0d %h",
                       xf, row_m, col_m, msg_m, e.r, e.c, e.m);
            end
          end
          xf++;
          last_xf = cyc;
          if (extra && xf == 3) start = 1'b1;
        end
        prev_stall = !rdy;
        prow = int'(row_m);
        pcol = int'(col_m);
      end else begin
        if (prev_stall) begin
          vectors++; miscompares++;
          $display("FAIL val_drop: val=0 at cycle %0d, required 1", cyc);
        end
        prev_stall = 0;
      end
      if (clr_m || done_m) begin
        exp_clr = bp ? last_xf + 1 : settle + 1 + SIZE * SIZE;
        vectors++;
        if (cyc != exp_clr || !clr_m || !done_m || !busy_m || xf != SIZE * SIZE) begin
          miscompares++;
          $display("FAIL clear: cycle %0d clr=%b done=%b busy=%b xf=%0d, required cycle %0d 1 1 1 16",
                   cyc, clr_m, done_m, busy_m, xf, exp_clr);
        end
        if (extra) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy_m !== 1'b0 || clr_m !== 1'b0 || done_m !== 1'b0) begin
          miscompares++;
          $display("FAIL post_clear: busy=%b clr=%b done=%b, required 0 0 0", busy_m, clr_m, done_m);
        end
        for (int t = 0; t < tail; t++) begin
          @(negedge clk);
          vectors++;
          if ({busy_m, val_m, clr_m, done_m} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_tail: busy=%b val=%b clr=%b done=%b, required 0",
                     busy_m, val_m, clr_m, done_m);
          end
        end
        fin = 1;
      end
    end
    vectors++;
    if (xf != SIZE * SIZE || q.size() != 0) begin
      miscompares++;
      $display("FAIL xfer_count: %0d transfers, %0d left, required 16 and 0", xf, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; col_major = 1'b0; rdy = 1'b1; use0 = 1'b0; seed = 16'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy6, if6.val, clr6, done6} !== 4'b0 || row6 !== 0 || col6 !== 0) begin
      miscompares++;
      $display("FAIL reset6: busy=%b val=%b clr=%b done=%b row=%0d col=%0d, required 0",
               busy6, if6.val, clr6, done6, row6, col6);
    end
    vectors++;
    if ({busy0, if0.val, clr0, done0} !== 4'b0 || row0 !== 0 || col0 !== 0) begin
      miscompares++;
      $display("FAIL reset0: busy=%b val=%b clr=%b done=%b row=%0d col=%0d, required 0",
               busy0, if0.val, clr0, done0, row0, col0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_row_major();
    use0 = 1'b0; seed = 16'h1111;
    run_drain(1'b0, 1'b0, 1'b0, 0, 2);
  endtask

  task automatic test_col_major();
    use0 = 1'b0; seed = 16'h2222;
    run_drain(1'b1, 1'b0, 1'b0, 0, 2);
  endtask

  task automatic test_backpressure();
    use0 = 1'b0; seed = 16'h3333;
    run_drain(1'b0, 1'b1, 1'b0, 0, 2);
    seed = 16'h4444;
    run_drain(1'b1, 1'b1, 1'b0, 0, 2);
  endtask

  task automatic test_settle_zero();
    use0 = 1'b1; seed = 16'h5555;
    run_drain(1'b0, 1'b0, 1'b1, 0, 3);
    use0 = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    use0 = 1'b0; seed = 16'h6666;
    run_drain(1'b0, 1'b0, 1'b0, 5, 0);
    run_drain(1'b0, 1'b0, 1'b0, 0, 2);
  endtask

  task automatic test_back_to_back();
    use0 = 1'b0; seed = 16'h7777;
    run_drain(1'b1, 1'b0, 1'b0, 0, 0);
    run_drain(1'b1, 1'b0, 1'b0, 0, 2);
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_backpressure();
    test_settle_zero();
    test_reset_mid_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
